// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 op
// encodings, FSM state encodings and the signed-overflow constant helper.
package muldiv_unit_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        MULDIV_OP_MUL    = 3'b000,
        MULDIV_OP_MULH   = 3'b001,
        MULDIV_OP_MULHSU = 3'b010,
        MULDIV_OP_MULHU  = 3'b011,
        MULDIV_OP_DIV    = 3'b100,
        MULDIV_OP_DIVU   = 3'b101,
        MULDIV_OP_REM    = 3'b110,
        MULDIV_OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    // Most negative signed value for a given width (1 << (xlen-1)).
    function automatic logic [MAX_XLEN-1:0] signed_min(input int xlen);
        logic [MAX_XLEN-1:0] v;
        v = {MAX_XLEN{1'b0}};
        v[xlen-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// UNROLL-wide combinational iteration step shared by the shift-add
// multiplier and the restoring divider.
//   multiply: acc = {partial_high, multiplier_low}, opnd = |multiplicand|
//   divide:   acc = {remainder, quotient/dividend},  opnd = |divisor|
module muldiv_iter_core
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [2*XLEN-1:0] work;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   diff;
    logic [XLEN:0]     sum;
    logic              ge;

    // Apply UNROLL consecutive add-shift or shift-subtract steps.
    always_comb begin
        work   = acc_in;
        rem_sh = {(XLEN+1){1'b0}};
        diff   = {XLEN{1'b0}};
        sum    = {(XLEN+1){1'b0}};
        ge     = 1'b0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div) begin
                // Shifted remainder needs one extra bit before the compare.
                rem_sh = work[2*XLEN-1:XLEN-1];
                ge     = (rem_sh >= {1'b0, opnd});
                diff   = rem_sh[XLEN-1:0] - opnd;
                work   = {(ge ? diff : rem_sh[XLEN-1:0]), work[XLEN-2:0], ge};
            end else begin
                sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
                work = {sum, work[XLEN-1:1]};
            end
        end
        acc_out = work;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execution unit: FSM, iteration counter, operand
// latching, sign fix-up and fast paths (divide by zero, signed overflow).
// Optional macro MULDIV_FAST_MUL_EN: all MUL* ops use one combinational
// multiplier and complete on the fast path; the divider is unchanged.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int ITERS = XLEN / UNROLL;
    localparam int CW    = $clog2(ITERS);
    localparam logic [MAX_XLEN-1:0] SMIN_FULL = signed_min(XLEN);
    localparam logic [XLEN-1:0]     SMIN      = SMIN_FULL[XLEN-1:0];
    localparam logic [XLEN-1:0]     ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]     ONES      = {XLEN{1'b1}};

    muldiv_state_e     state_r, state_next;
    logic [CW-1:0]     count_r, count_next;
    logic [2*XLEN-1:0] acc_r, acc_next;
    logic [XLEN-1:0]   opnd_r, opnd_next;
    logic              neg_r, neg_next;
    logic [2:0]        op_r, op_next;
    logic [XLEN-1:0]   result_r, result_next;

    logic              sign_a_s, sign_b_s, neg_in_s, div0_s, ovf_s, fast_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s, fast_res_s, final_res_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic [2*XLEN-1:0] core_out_s, prod_s;
    logic              core_div_s;

    // Operand sign extraction per op (MUL low half is sign-agnostic).
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (op)
            MULDIV_OP_MULH, MULDIV_OP_DIV, MULDIV_OP_REM: begin
                sign_a_s = rs1[XLEN-1];
                sign_b_s = rs2[XLEN-1];
            end
            MULDIV_OP_MULHSU: sign_a_s = rs1[XLEN-1];
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
    end

    assign abs_a_s  = sign_a_s ? -rs1 : rs1;
    assign abs_b_s  = sign_b_s ? -rs2 : rs2;
    assign neg_in_s = (op == MULDIV_OP_REM) ? sign_a_s : (sign_a_s ^ sign_b_s);
    assign div0_s   = op[2] && (rs2 == ZERO);
    assign ovf_s    = ((op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM)) &&
                      (rs1 == SMIN) && (rs2 == ONES);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fmag_s, fprod_s;
    assign fmag_s     = {ZERO, abs_a_s} * {ZERO, abs_b_s};
    assign fprod_s    = neg_in_s ? -fmag_s : fmag_s;
    assign core_div_s = 1'b1;
`else
    assign core_div_s = op_r[2];
`endif

    // Fast-path detection and result, decided at accept.
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = ZERO;
        if (div0_s) begin
            fast_s     = 1'b1;
            fast_res_s = op[1] ? rs1 : ONES;
        end else if (ovf_s) begin
            fast_s     = 1'b1;
            fast_res_s = op[1] ? ZERO : rs1;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!op[2]) begin
            fast_s     = 1'b1;
            fast_res_s = (op == MULDIV_OP_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
`endif
        end else begin
            fast_s     = 1'b0;
            fast_res_s = ZERO;
        end
    end

    muldiv_iter_core #(.XLEN(XLEN), .UNROLL(UNROLL)) u_core (
        .is_div  (core_div_s),
        .acc_in  (acc_r),
        .opnd    (opnd_r),
        .acc_out (core_out_s)
    );

    assign prod_s = neg_r ? -core_out_s : core_out_s;
    assign quo_s  = neg_r ? -core_out_s[XLEN-1:0] : core_out_s[XLEN-1:0];
    assign rem_s  = neg_r ? -core_out_s[2*XLEN-1:XLEN] : core_out_s[2*XLEN-1:XLEN];

    // Sign fix-up and half selection for the final iteration.
    always_comb begin
        if (op_r[2]) begin
            final_res_s = op_r[1] ? rem_s : quo_s;
        end else if (op_r == MULDIV_OP_MUL) begin
            final_res_s = prod_s[XLEN-1:0];
        end else begin
            final_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath-load logic.
    always_comb begin
        state_next  = state_r;
        count_next  = count_r;
        acc_next    = acc_r;
        opnd_next   = opnd_r;
        neg_next    = neg_r;
        op_next     = op_r;
        result_next = result_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !flush) begin
                    op_next    = op;
                    neg_next   = neg_in_s;
                    count_next = {CW{1'b0}};
                    if (fast_s) begin
                        state_next  = ST_DONE;
                        result_next = fast_res_s;
                    end else begin
                        state_next = ST_RUN;
                        acc_next   = {ZERO, (op[2] ? abs_a_s : abs_b_s)};
                        opnd_next  = op[2] ? abs_b_s : abs_a_s;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (count_r == CW'(ITERS - 1)) begin
                    state_next  = ST_DONE;
                    acc_next    = core_out_s;
                    result_next = final_res_s;
                end else begin
                    acc_next   = core_out_s;
                    count_next = count_r + CW'(1'b1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Datapath registers: counter, operands, sign flag, latched op, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= {CW{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= ZERO;
            neg_r    <= 1'b0;
            op_r     <= 3'b000;
            result_r <= ZERO;
        end else begin
            count_r  <= count_next;
            acc_r    <= acc_next;
            opnd_r   <= opnd_next;
            neg_r    <= neg_next;
            op_r     <= op_next;
            result_r <= result_next;
        end
    end

    assign busy   = (state_r == ST_RUN);
    assign valid  = (state_r == ST_DONE);
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, UNROLL=1).
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        flush = 1'b0;
    logic        busy, valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Present a request at the current negedge; returns right after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
    endtask

    // Observe cycles 1..lat (plus two more unless chaining) after an accept.
    task automatic watch(input string tag, input int lat, input logic [31:0] exp, input bit chain);
        int vcyc = 0;
        int pulses = 0;
        int busy_err = 0;
        logic [31:0] res_at = 32'hDEADBEEF;
        int last = chain ? lat : lat + 2;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy !== (c < lat)) busy_err++;
            if (valid === 1'b1) begin
                pulses++;
                if (vcyc == 0) begin
                    vcyc = c;
                    res_at = result;
                end
            end
        end
        check({tag, ".valid_cycle"}, 32'(vcyc), 32'(lat));
        check({tag, ".pulses"}, 32'(pulses), 32'd1);
        check({tag, ".busy_errs"}, 32'(busy_err), 32'd0);
        check({tag, ".result"}, res_at, exp);
        if (!chain) check({tag, ".hold"}, result, exp);
    endtask

    initial begin
        int busy_err;
        int vcnt;
        #1;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.valid", {31'd0, valid}, 32'd0);
        check("reset.result", result, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MUL, 32'd7, 32'hFFFFFFFD);     watch("mul", MUL_LAT, 32'hFFFFFFEB, 1'b0);
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);  watch("mulhu", MUL_LAT, 32'hFFFFFFFE, 1'b0);
        issue(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);   watch("mulh", MUL_LAT, 32'h00000000, 1'b0);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF); watch("mulhsu", MUL_LAT, 32'hFFFFFFFF, 1'b0);

        issue(OP_DIV, 32'hFFFFFFEC, 32'd3);  watch("div", DIV_LAT, 32'hFFFFFFFA, 1'b0);
        issue(OP_REM, 32'hFFFFFFEC, 32'd3);  watch("rem", DIV_LAT, 32'hFFFFFFFE, 1'b1);
        issue(OP_DIVU, 32'hFFFFFFEC, 32'd3); watch("divu_b2b", DIV_LAT, 32'h5555554E, 1'b0);

        issue(OP_DIVU, 32'd5, 32'd0);  watch("divu0", 1, 32'hFFFFFFFF, 1'b0);
        issue(OP_REMU, 32'd5, 32'd0);  watch("remu0", 1, 32'h00000005, 1'b0);
        issue(OP_REM, 32'h80000000, 32'hFFFFFFFF); watch("rem_ovf", 1, 32'h00000000, 1'b0);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF); watch("div_ovf", 1, 32'h80000000, 1'b0);

        // Flush in cycle 10 of a DIV; restart in cycle 11.
        issue(OP_DIV, 32'd1000, 32'd7);
        busy_err = 0;
        vcnt = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 10 && busy !== 1'b1) busy_err++;
            if (valid === 1'b1) vcnt++;
            if (c == 10) flush = 1'b1;
        end
        flush = 1'b0;
        check("flush.busy_run", 32'(busy_err), 32'd0);
        check("flush.busy_after", {31'd0, busy}, 32'd0);
        check("flush.no_valid", 32'(vcnt), 32'd0);
        check("flush.result_kept", result, 32'h80000000);
        issue(OP_DIVU, 32'd100, 32'd7); watch("after_flush", DIV_LAT, 32'h0000000E, 1'b0);

        // Asynchronous reset in cycle 5 of a DIV.
        issue(OP_DIV, 32'd1000, 32'd7);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("arst.busy", {31'd0, busy}, 32'd0);
        check("arst.valid", {31'd0, valid}, 32'd0);
        check("arst.result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(OP_REMU, 32'd17, 32'd5); watch("remu_after_rst", DIV_LAT, 32'h00000002, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
